// File: rtl/uart_byte_fifo_pkg.sv
// -----------------------------------------------------------------------------
// uart_byte_fifo_pkg
// Shared constants for the UART byte FIFO slice.
//   DEFAULT_DEPTH : default number of byte entries (power of two, 2..512)
//   DEFAULT_WIDTH : default data bits per entry
//   SLOTS_FREE_W  : width of the slots_free status output (holds 0..512)
// -----------------------------------------------------------------------------
package uart_byte_fifo_pkg;

   localparam int DEFAULT_DEPTH = 512;
   localparam int DEFAULT_WIDTH = 8;
   localparam int SLOTS_FREE_W  = 10;

endpackage : uart_byte_fifo_pkg

// File: rtl/fifo_storage_ram.sv
// -----------------------------------------------------------------------------
// fifo_storage_ram
// DEPTH x WIDTH storage array for the UART byte FIFO. One synchronous write
// port and one asynchronous (combinational) read port, so the head entry
// falls through to the read port as soon as the read pointer addresses it.
// Contents are deliberately not reset.
// Ports:
//   clk          : rising-edge clock for the write port
//   write_enable : write write_data to write_addr on this edge
//   write_addr   : write address (FIFO write pointer)
//   write_data   : data to store
//   read_addr    : read address (FIFO read pointer)
//   read_data    : contents of read_addr, combinational
// -----------------------------------------------------------------------------
module fifo_storage_ram import uart_byte_fifo_pkg::*; #(
   parameter int DEPTH = DEFAULT_DEPTH,
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             write_enable,
   input  logic [AW-1:0]    write_addr,
   input  logic [WIDTH-1:0] write_data,
   input  logic [AW-1:0]    read_addr,
   output logic [WIDTH-1:0] read_data
);

   logic [WIDTH-1:0] mem_r [DEPTH];

   // Synchronous write port.
   always_ff @(posedge clk) begin
      if (write_enable) begin
         mem_r[write_addr] <= write_data;
      end
   end

   // Asynchronous read port gives first-word-fall-through at the top level.
   assign read_data = mem_r[read_addr];

endmodule : fifo_storage_ram

// File: rtl/uart_byte_fifo.sv
// -----------------------------------------------------------------------------
// uart_byte_fifo
// First-word-fall-through byte FIFO for a UART datapath.
// Ports:
//   clk          : rising-edge clock for all state
//   reset        : asynchronous, active-high; empties the FIFO
//   write_enable : push write_data this cycle (dropped when full, no pop)
//   write_data   : byte to push
//   read_enable  : pop the head entry this cycle (ignored when empty)
//   read_data    : current head entry, valid whenever not_empty=1
//   slots_free   : DEPTH minus occupancy, zero-extended to 10 bits
//   not_empty    : high when occupancy > 0
//   overflow     : (only with UART_BYTE_FIFO_OVERFLOW_FLAG_EN) sticky flag,
//                  set after any dropped push, cleared only by reset
// Configuration macro: UART_BYTE_FIFO_OVERFLOW_FLAG_EN
// -----------------------------------------------------------------------------
module uart_byte_fifo import uart_byte_fifo_pkg::*; #(
   parameter int DEPTH = DEFAULT_DEPTH,
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    write_enable,
   input  logic [WIDTH-1:0]        write_data,
   input  logic                    read_enable,
   output logic [WIDTH-1:0]        read_data,
   output logic [SLOTS_FREE_W-1:0] slots_free,
`ifdef UART_BYTE_FIFO_OVERFLOW_FLAG_EN
   output logic                    overflow,
`endif
   output logic                    not_empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   localparam logic [AW-1:0]           PTR_ONE_C     = AW'(1);
   localparam logic [CW-1:0]           CNT_ONE_C     = CW'(1);
   localparam logic [CW-1:0]           CNT_DEPTH_C   = CW'(DEPTH);
   localparam logic [SLOTS_FREE_W-1:0] SLOTS_DEPTH_C = SLOTS_FREE_W'(DEPTH);

   logic [AW-1:0]           wr_ptr_r;
   logic [AW-1:0]           rd_ptr_r;
   logic [CW-1:0]           count_r;
   logic                    not_empty_r;
   logic [SLOTS_FREE_W-1:0] slots_free_r;

   logic                    push_s;
   logic                    pop_s;
   logic                    ram_we_s;
   logic [CW-1:0]           count_nxt_s;
   logic [SLOTS_FREE_W-1:0] slots_free_nxt_s;

   // Accept/ignore decisions and next occupancy; a pop frees room for a push
   // in the same cycle, which is what lets a full FIFO stream.
   always_comb begin
      pop_s            = 1'b0;
      push_s           = 1'b0;
      count_nxt_s      = count_r;
      slots_free_nxt_s = slots_free_r;

      if (read_enable && (count_r != {CW{1'b0}})) begin
         pop_s = 1'b1;
      end else begin
         pop_s = 1'b0;
      end

      if (write_enable && ((count_r < CNT_DEPTH_C) || pop_s)) begin
         push_s = 1'b1;
      end else begin
         push_s = 1'b0;
      end

      case ({push_s, pop_s})
         2'b10:   count_nxt_s = count_r + CNT_ONE_C;
         2'b01:   count_nxt_s = count_r - CNT_ONE_C;
         default: count_nxt_s = count_r;
      endcase

      slots_free_nxt_s = SLOTS_DEPTH_C - SLOTS_FREE_W'(count_nxt_s);
   end

   // Never write the array on an edge that reset is holding off.
   assign ram_we_s = push_s & ~reset;

   // Pointers, occupancy and registered status flags.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_r     <= {AW{1'b0}};
         rd_ptr_r     <= {AW{1'b0}};
         count_r      <= {CW{1'b0}};
         not_empty_r  <= 1'b0;
         slots_free_r <= SLOTS_DEPTH_C;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
         end
         count_r      <= count_nxt_s;
         not_empty_r  <= (count_nxt_s != {CW{1'b0}});
         slots_free_r <= slots_free_nxt_s;
      end
   end

   fifo_storage_ram #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH),
      .AW    (AW)
   ) u_storage (
      .clk          (clk),
      .write_enable (ram_we_s),
      .write_addr   (wr_ptr_r),
      .write_data   (write_data),
      .read_addr    (rd_ptr_r),
      .read_data    (read_data)
   );

   assign not_empty  = not_empty_r;
   assign slots_free = slots_free_r;

`ifdef UART_BYTE_FIFO_OVERFLOW_FLAG_EN
   logic overflow_r;
   logic drop_s;

   assign drop_s = write_enable & ~push_s;

   // Sticky record of any push dropped because the FIFO was full.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overflow_r <= 1'b0;
      end else if (drop_s) begin
         overflow_r <= 1'b1;
      end
   end

   assign overflow = overflow_r;
`endif

endmodule : uart_byte_fifo

// File: tb/tb_uart_byte_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_byte_fifo
// Self-checking bench for uart_byte_fifo. A queue-based reference model
// decides which pushes/pops are accepted; every accepted pop places the
// expected byte into a scoreboard queue that a separate monitor process
// drains whenever the DUT presents a pop (read_enable with not_empty).
// Status outputs are compared against the model after every edge.
// -----------------------------------------------------------------------------
module tb_uart_byte_fifo;

   localparam int DEPTH = 512;

   logic       clk;
   logic       reset;
   logic       write_enable;
   logic [7:0] write_data;
   logic       read_enable;
   logic [7:0] read_data;
   logic [9:0] slots_free;
   logic       not_empty;
`ifdef UART_BYTE_FIFO_OVERFLOW_FLAG_EN
   logic       overflow;
`endif

   uart_byte_fifo dut (
      .clk          (clk),
      .reset        (reset),
      .write_enable (write_enable),
      .write_data   (write_data),
      .read_enable  (read_enable),
      .read_data    (read_data),
      .slots_free   (slots_free),
`ifdef UART_BYTE_FIFO_OVERFLOW_FLAG_EN
      .overflow     (overflow),
`endif
      .not_empty    (not_empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int         tests;
   int         fails;
   logic [7:0] model_q[$];
   logic [7:0] exp_q[$];
   logic       model_ovf;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare all status outputs against the model's post-edge state.
   task automatic check_status(input string tag);
      check({tag, " slots_free"}, 32'(slots_free), 32'(DEPTH - model_q.size()));
      check({tag, " not_empty"}, 32'(not_empty), 32'(model_q.size() > 0));
      if (model_q.size() > 0) begin
         check({tag, " head"}, 32'(read_data), 32'(model_q[0]));
      end
`ifdef UART_BYTE_FIFO_OVERFLOW_FLAG_EN
      check({tag, " overflow"}, 32'(overflow), 32'(model_ovf));
`endif
   endtask

   // One clock of stimulus; called just after a rising edge.
   task automatic cycle(input logic we, input logic [7:0] wd, input logic re, input string tag);
      logic pop_ok;
      logic push_ok;
      write_enable = we;
      write_data   = wd;
      read_enable  = re;
      pop_ok  = re && (model_q.size() > 0);
      push_ok = we && ((model_q.size() < DEPTH) || pop_ok);
      if (pop_ok) exp_q.push_back(model_q.pop_front());
      if (push_ok) model_q.push_back(wd);
      if (we && !push_ok) model_ovf = 1'b1;
      @(posedge clk);
      #1;
      check_status(tag);
   endtask

   initial begin
      logic [7:0] d;
      tests        = 0;
      fails        = 0;
      model_ovf    = 1'b0;
      reset        = 1'b1;
      write_enable = 1'b0;
      write_data   = 8'h00;
      read_enable  = 1'b0;

      // Scoreboard monitor: every DUT pop must match the oldest expected byte.
      fork
         forever begin
            @(negedge clk);
            if (!reset && read_enable && not_empty) begin
               if (exp_q.size() == 0) begin
                  check("unexpected pop", 32'(read_data), 32'hFFFF_FFFF);
               end else begin
                  check("pop data", 32'(read_data), 32'(exp_q.pop_front()));
               end
            end
         end
      join_none

      // Reset state and pop-while-empty.
      repeat (3) @(posedge clk);
      #1;
      check_status("reset");
      reset = 1'b0;
      cycle(1'b0, 8'h00, 1'b1, "empty pop");

      // Three pushes then three pops.
      cycle(1'b1, 8'h41, 1'b0, "push41");
      cycle(1'b1, 8'h42, 1'b0, "push42");
      cycle(1'b1, 8'h43, 1'b0, "push43");
      check("three pushes slots", 32'(slots_free), 32'd509);
      for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1, "pop3");
      check("drained not_empty", 32'(not_empty), 32'd0);

      // Fill to full, drop one push, drain in order.
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i), 1'b0, "fill");
      check("full slots", 32'(slots_free), 32'd0);
      cycle(1'b1, 8'h99, 1'b0, "drop99");
`ifdef UART_BYTE_FIFO_OVERFLOW_FLAG_EN
      check("overflow set", 32'(overflow), 32'd1);
`endif
      for (int i = 0; i < DEPTH; i++) cycle(1'b0, 8'h00, 1'b1, "drain");

      // Simultaneous push/pop while full; 0x55 becomes the tail.
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0, "refill");
      cycle(1'b1, 8'h55, 1'b1, "full pushpop");
      check("full pushpop slots", 32'(slots_free), 32'd0);
      check("tail is 55", 32'(model_q[DEPTH-1]), 32'h55);
      for (int i = 0; i < DEPTH; i++) cycle(1'b0, 8'h00, 1'b1, "drain2");

      // Simultaneous push/pop while empty: pop ignored.
      cycle(1'b1, 8'h7E, 1'b1, "empty pushpop");
      check("empty pushpop data", 32'(read_data), 32'h7E);
      check("empty pushpop slots", 32'(slots_free), 32'd511);
      cycle(1'b0, 8'h00, 1'b1, "pop7e");

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         cycle(1'($urandom_range(0, 99) < 55), 8'($urandom_range(0, 255)),
               1'($urandom_range(0, 99) < 50), "random");
      end

      // Asynchronous reset mid-stream with entries present.
      while (model_q.size() > 0) cycle(1'b0, 8'h00, 1'b1, "pre-reset drain");
      for (int i = 0; i < 10; i++) cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0, "ten");
      write_enable = 1'b1;
      write_data   = 8'hAA;
      read_enable  = 1'b1;
      #2;
      reset = 1'b1;
      #1;
      model_q.delete();
      model_ovf = 1'b0;
      check("async reset not_empty", 32'(not_empty), 32'd0);
      check("async reset slots", 32'(slots_free), 32'd512);
      @(posedge clk);
      #1;
      check_status("reset held");
      reset = 1'b0;
      cycle(1'b1, 8'h11, 1'b0, "push11");
      check("post reset data", 32'(read_data), 32'h11);
      cycle(1'b0, 8'h00, 1'b1, "pop11");
      cycle(1'b0, 8'h00, 1'b0, "idle");

      check("scoreboard leftover", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_uart_byte_fifo
